// File: rtl/lcd_dbg_pkg.sv
// Shared types and constants for the multi-channel HD44780 debug readout.
//   lcd_state_e : top-level sequencer states
//   lcd_phase_e : per-item phase inside a sending state (upper nibble, lower nibble, wait)
//   tx_state_e  : nibble transmitter timing states
//   hex2ascii   : 4-bit value to upper-case ASCII hex digit
package lcd_dbg_pkg;

  typedef enum logic [2:0] {
    StPwrWait,
    StInitNib,
    StCfg,
    StClrWait,
    StIdle,
    StSetAddr,
    StWrChar
  } lcd_state_e;

  typedef enum logic [1:0] {
    PhHi,
    PhLo,
    PhWait
  } lcd_phase_e;

  typedef enum logic [1:0] {
    TxIdle,
    TxSetup,
    TxHigh,
    TxHold
  } tx_state_e;

  localparam logic [7:0] CMD_FUNC_SET  = 8'h28;  // 4-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_ENTRY     = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_SET_ADDR  = 8'h80;  // DDRAM address 0

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_DASH  = 8'h2D;
  localparam logic [7:0] CHAR_QMARK = 8'h3F;

  function automatic logic [7:0] hex2ascii(input logic [3:0] n);
    if (n <= 4'd9) begin
      return 8'h30 + {4'h0, n};
    end
    return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Single-nibble HD44780 write strobe generator.
// A request is taken when idle, or in the final hold cycle (done_o) so that the lower nibble of a
// byte follows the upper one with no gap. Timing: data/RS valid PULSE_CYC cycles, E high PULSE_CYC
// cycles, then E low with data held PULSE_CYC cycles. Data and RS return to 0 when idle.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i       : request a nibble write (nib_i, rs_i sampled with it)
//   e_o, rs_o     : registered E and RS
//   data_o        : registered DB7..DB4
//   done_o        : high in the last hold cycle of a nibble
module lcd_nibble_tx
  import lcd_dbg_pkg::*;
#(
  parameter int unsigned PULSE_CYC = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [3:0] nib_i,
  input  logic       rs_i,
  output logic       e_o,
  output logic       rs_o,
  output logic [3:0] data_o,
  output logic       done_o
);

  localparam int unsigned CW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

  tx_state_e   st_q;
  logic [CW-1:0] cnt_q;
  logic        e_q;
  logic        rs_q;
  logic [3:0]  data_q;
  logic        last;

  assign last   = (cnt_q == CW'(PULSE_CYC - 1));
  assign done_o = (st_q == TxHold) && last;
  assign e_o    = e_q;
  assign rs_o   = rs_q;
  assign data_o = data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q   <= TxIdle;
      cnt_q  <= '0;
      e_q    <= 1'b0;
      rs_q   <= 1'b0;
      data_q <= 4'h0;
    end else begin
      unique case (st_q)
        TxIdle: begin
          if (start_i) begin
            data_q <= nib_i;
            rs_q   <= rs_i;
            cnt_q  <= '0;
            st_q   <= TxSetup;
          end
        end
        TxSetup: begin
          if (last) begin
            cnt_q <= '0;
            e_q   <= 1'b1;
            st_q  <= TxHigh;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        TxHigh: begin
          if (last) begin
            cnt_q <= '0;
            e_q   <= 1'b0;
            st_q  <= TxHold;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        TxHold: begin
          if (last) begin
            cnt_q <= '0;
            if (start_i) begin
              data_q <= nib_i;
              rs_q   <= rs_i;
              st_q   <= TxSetup;
            end else begin
              data_q <= 4'h0;
              rs_q   <= 1'b0;
              st_q   <= TxIdle;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: st_q <= TxIdle;
      endcase
    end
  end

endmodule

// File: rtl/lcd_hex_dbg_multi.sv
// Multi-channel HD44780 (4-bit) debug readout. After power-on init, line 1 is refreshed forever
// as "LL VVVV": channel label, space, selected channel value in upper-case hex, MSB first.
// Optional macro LCD_SEL_CHANGE_EN: a change of ch_sel restarts the display without waiting for
// the refresh period (immediately when idle, at frame end when seen mid-frame).
//   qzt_clk, rst_n : clock, asynchronous active-low reset
//   ch_data        : CHANNELS values of DATA_W bits, channel 0 in the LSBs
//   ch_sel         : channel select; values >= CHANNELS show "?? ----"
//   lcd_flags      : bit0 = E, bit1 = RS
//   lcd_data       : DB7..DB4
//   init_done      : high once init completes
//   frame_done     : one-cycle pulse after the last character of a frame
module lcd_hex_dbg_multi
  import lcd_dbg_pkg::*;
#(
  parameter int unsigned            CHANNELS    = 4,
  parameter int unsigned            DATA_W      = 16,
  parameter logic [CHANNELS*16-1:0] LABELS      = "PCSPABHL",
  parameter int unsigned            PWR_CYC     = 753664,
  parameter int unsigned            INIT_CYC    = 212960,
  parameter int unsigned            CMD_CYC     = 8176,
  parameter int unsigned            CLR_CYC     = 98304,
  parameter int unsigned            PULSE_CYC   = 16,
  parameter int unsigned            REFRESH_CYC = 1048576,
  localparam int unsigned           SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         qzt_clk,
  input  logic                         rst_n,
  input  logic [CHANNELS*DATA_W-1:0]   ch_data,
  input  logic [SEL_W-1:0]             ch_sel,
  output logic [1:0]                   lcd_flags,
  output logic [3:0]                   lcd_data,
  output logic                         init_done,
  output logic                         frame_done
);

  localparam int unsigned NDIG  = DATA_W / 4;
  localparam int unsigned NCHAR = 3 + NDIG;

  lcd_state_e        state_q;
  lcd_phase_e        ph_q;
  logic              issued_q;  // current nibble already handed to the transmitter
  logic [3:0]        idx_q;
  logic [31:0]       cnt_q;
  logic              init_done_q;
  logic              frame_done_q;
  logic [15:0]       lab_q;
  logic [DATA_W-1:0] val_q;
  logic              oor_q;
`ifdef LCD_SEL_CHANGE_EN
  logic [SEL_W-1:0]  sel_q;
`endif

  // Live channel selection; only sampled at the start of SET_ADDR.
  logic              sel_ok;
  logic [DATA_W-1:0] sel_val;
  logic [15:0]       sel_lab;

  always_comb begin
    sel_ok  = 1'b0;
    sel_val = '0;
    sel_lab = {CHAR_QMARK, CHAR_QMARK};
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (32'(ch_sel) == c) begin
        sel_ok  = 1'b1;
        sel_val = ch_data[c*DATA_W +: DATA_W];
        sel_lab = LABELS[(CHANNELS-1-c)*16 +: 16];
      end
    end
  end

  // Character for position idx_q of the frame.
  logic [3:0]        dig;
  logic [DATA_W-1:0] val_sh;
  logic [7:0]        char_byte;

  always_comb begin
    dig    = idx_q - 4'd3;
    val_sh = val_q << {dig, 2'b00};
    if (idx_q == 4'd0) begin
      char_byte = lab_q[15:8];
    end else if (idx_q == 4'd1) begin
      char_byte = lab_q[7:0];
    end else if (idx_q == 4'd2) begin
      char_byte = CHAR_SPACE;
    end else if (oor_q) begin
      char_byte = CHAR_DASH;
    end else begin
      char_byte = hex2ascii(val_sh[DATA_W-1 -: 4]);
    end
  end

  // Item currently being sent; single nibbles travel in the upper half of cur_byte.
  logic [7:0]  cur_byte;
  logic        cur_rs;
  logic        cur_single;
  logic        sending;
  logic [31:0] wait_len;

  always_comb begin
    cur_byte   = CMD_SET_ADDR;
    cur_rs     = 1'b0;
    cur_single = 1'b0;
    sending    = 1'b0;
    wait_len   = 32'(CMD_CYC);
    unique case (state_q)
      StInitNib: begin
        sending    = 1'b1;
        cur_single = 1'b1;
        cur_byte   = (idx_q == 4'd3) ? 8'h20 : 8'h30;
        if (idx_q == 4'd0) wait_len = 32'(INIT_CYC);
      end
      StCfg: begin
        sending = 1'b1;
        unique case (idx_q[1:0])
          2'd0: cur_byte = CMD_FUNC_SET;
          2'd1: cur_byte = CMD_ENTRY;
          2'd2: cur_byte = CMD_DISP_ON;
          2'd3: cur_byte = CMD_CLEAR;
        endcase
      end
      StSetAddr: sending = 1'b1;
      StWrChar: begin
        sending  = 1'b1;
        cur_rs   = 1'b1;
        cur_byte = char_byte;
      end
      default: ;
    endcase
  end

  logic       tx_start;
  logic [3:0] tx_nib;
  logic       tx_e;
  logic       tx_rs;
  logic       tx_done;

  // Lower nibble is requested in the upper nibble's done cycle so the two run back to back.
  assign tx_start = sending && (ph_q == PhHi) && (!issued_q || (tx_done && !cur_single));
  assign tx_nib   = issued_q ? cur_byte[3:0] : cur_byte[7:4];

  lcd_nibble_tx #(
    .PULSE_CYC(PULSE_CYC)
  ) u_tx (
    .clk_i  (qzt_clk),
    .rst_ni (rst_n),
    .start_i(tx_start),
    .nib_i  (tx_nib),
    .rs_i   (cur_rs),
    .e_o    (tx_e),
    .rs_o   (tx_rs),
    .data_o (lcd_data),
    .done_o (tx_done)
  );

  assign lcd_flags  = {tx_rs, tx_e};
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StPwrWait;
      ph_q         <= PhHi;
      issued_q     <= 1'b0;
      idx_q        <= '0;
      cnt_q        <= '0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      lab_q        <= '0;
      val_q        <= '0;
      oor_q        <= 1'b0;
`ifdef LCD_SEL_CHANGE_EN
      sel_q        <= '0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        StPwrWait: begin
          if (cnt_q == 32'(PWR_CYC - 1)) begin
            state_q  <= StInitNib;
            idx_q    <= '0;
            ph_q     <= PhHi;
            issued_q <= 1'b0;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StClrWait: begin
          if (cnt_q == 32'(CLR_CYC - 1)) begin
            init_done_q <= 1'b1;
            state_q     <= StSetAddr;
            ph_q        <= PhHi;
            issued_q    <= 1'b0;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StIdle: begin
`ifdef LCD_SEL_CHANGE_EN
          if (ch_sel != sel_q) begin
            state_q  <= StSetAddr;
            ph_q     <= PhHi;
            issued_q <= 1'b0;
            cnt_q    <= '0;
          end else
`endif
          if (cnt_q == 32'(REFRESH_CYC - 1)) begin
            state_q  <= StSetAddr;
            ph_q     <= PhHi;
            issued_q <= 1'b0;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StInitNib, StCfg, StSetAddr, StWrChar: begin
          // Snapshot on the first cycle of SET_ADDR so a frame never mixes old and new data.
          if (state_q == StSetAddr && ph_q == PhHi && !issued_q) begin
            lab_q <= sel_lab;
            val_q <= sel_val;
            oor_q <= !sel_ok;
`ifdef LCD_SEL_CHANGE_EN
            sel_q <= ch_sel;
`endif
          end
          unique case (ph_q)
            PhHi: begin
              if (!issued_q) begin
                issued_q <= 1'b1;
              end else if (tx_done) begin
                if (cur_single) begin
                  ph_q  <= PhWait;
                  cnt_q <= '0;
                end else begin
                  ph_q <= PhLo;
                end
              end
            end
            PhLo: begin
              if (tx_done) begin
                ph_q  <= PhWait;
                cnt_q <= '0;
              end
            end
            PhWait: begin
              if (cnt_q == wait_len - 32'd1) begin
                cnt_q    <= '0;
                ph_q     <= PhHi;
                issued_q <= 1'b0;
                idx_q    <= idx_q + 4'd1;
                if (state_q == StInitNib && idx_q == 4'd3) begin
                  state_q <= StCfg;
                  idx_q   <= '0;
                end else if (state_q == StCfg && idx_q == 4'd3) begin
                  state_q <= StClrWait;
                  idx_q   <= '0;
                end else if (state_q == StSetAddr) begin
                  state_q <= StWrChar;
                  idx_q   <= '0;
                end else if (state_q == StWrChar && idx_q == 4'(NCHAR - 1)) begin
                  idx_q        <= '0;
                  frame_done_q <= 1'b1;
`ifdef LCD_SEL_CHANGE_EN
                  state_q <= (ch_sel != sel_q) ? StSetAddr : StIdle;
`else
                  state_q <= StIdle;
`endif
                end
              end else begin
                cnt_q <= cnt_q + 32'd1;
              end
            end
            default: ph_q <= PhHi;
          endcase
        end
        default: state_q <= StPwrWait;
      endcase
    end
  end

endmodule
